// File: rtl/accel_sched_pkg.sv
// ---------------------------------------------------------------------------
// accel_sched_pkg
// Shared definitions for the accelerator scheduler:
//   - FSM state encoding
//   - register word offsets
//   - CTRL / STATUS bit positions
//   - accelerator unit-select constants
//   - STATUS word packing helper
// ---------------------------------------------------------------------------
package accel_sched_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StLaunch = 2'd1,
      StWait   = 2'd2
   } state_e;

   // Word offsets inside the 4-word peripheral window
   localparam logic [1:0] AddrCtrl   = 2'd0;
   localparam logic [1:0] AddrOpa    = 2'd1;
   localparam logic [1:0] AddrOpb    = 2'd2;
   localparam logic [1:0] AddrResult = 2'd3;

   // CTRL write fields
   localparam int unsigned CtrlStart = 0;
   localparam int unsigned CtrlUnit  = 1;
   localparam int unsigned CtrlClear = 2;

   // STATUS read fields
   localparam int unsigned StatBusy    = 0;
   localparam int unsigned StatDone    = 1;
   localparam int unsigned StatErr     = 2;
   localparam int unsigned StatTimeout = 3;
   localparam int unsigned StatOverrun = 4;
   localparam int unsigned StatUnit    = 5;

   // Unit select
   localparam logic UnitFact = 1'b0;
   localparam logic UnitFpm  = 1'b1;

   function automatic logic [31:0] pack_status(input logic busy,
                                               input logic done,
                                               input logic err,
                                               input logic timeout,
                                               input logic overrun,
                                               input logic unit);
      logic [31:0] s;
      s              = '0;
      s[StatBusy]    = busy;
      s[StatDone]    = done;
      s[StatErr]     = err;
      s[StatTimeout] = timeout;
      s[StatOverrun] = overrun;
      s[StatUnit]    = unit;
      return s;
   endfunction

endpackage

// File: rtl/accel_watchdog.sv
// ---------------------------------------------------------------------------
// accel_watchdog
// Cycle counter guarding one accelerator job.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   i_clr      zero the counter (job launch)
//   i_en       count one cycle (job waiting)
//   o_expired  counter has reached TIMEOUT-1
// ---------------------------------------------------------------------------
module accel_watchdog #(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned         CntW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0]     LastCnt = CntW'(TIMEOUT - 1);

   logic [CntW-1:0] r_cnt;

   // Saturates at the last count so a stalled enable never wraps back to 0
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_expired) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == LastCnt);

endmodule

// File: rtl/accel_sched.sv
// ---------------------------------------------------------------------------
// accel_sched
// Memory-mapped sequencer for the factorial unit and the FP multiplier.
// Latches operands, launches one job at a time with a single-cycle go pulse,
// waits for the selected unit's done under a watchdog and captures the result.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   we, addr, wdata, rdata     CPU register port (rdata combinational)
//   fact_go, fact_n            factorial launch pulse and operand
//   fact_done, fact_err,
//   fact_result                factorial completion, overflow and result
//   fpm_go, fpm_a, fpm_b       FPM launch pulse and operands
//   fpm_done, fpm_p            FPM completion and product
//   accel_done                 level copy of STATUS.done
// ---------------------------------------------------------------------------
module accel_sched
   import accel_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        fact_go,
   output logic [3:0]  fact_n,
   input  logic        fact_done,
   input  logic        fact_err,
   input  logic [31:0] fact_result,
   output logic        fpm_go,
   output logic [31:0] fpm_a,
   output logic [31:0] fpm_b,
   input  logic        fpm_done,
   input  logic [31:0] fpm_p,
   output logic        accel_done
);

   state_e      r_state;
   state_e      w_state_next;

   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic [31:0] r_result;
   logic [31:0] r_snap_a;
   logic [31:0] r_snap_b;
   logic        r_snap_unit;
   logic        r_done;
   logic        r_err;
   logic        r_timeout;
   logic        r_overrun;

   logic        w_done_d;
   logic        w_err_d;
   logic        w_timeout_d;
   logic        w_overrun_d;

   logic        w_ctrl_wr;
   logic        w_start_req;
   logic        w_clear_req;
   logic        w_start_acc;
   logic        w_busy;
   logic        w_sel_done;
   logic        w_complete;
   logic        w_expired;
   logic        w_timeout;
   logic        w_wd_clr;
   logic        w_wd_en;

   // ------------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------------
   assign w_ctrl_wr   = we && (addr == AddrCtrl);
   assign w_start_req = w_ctrl_wr && wdata[CtrlStart];
   assign w_clear_req = w_ctrl_wr && wdata[CtrlClear];
   assign w_start_acc = w_start_req && !w_busy;

   // Only the unit that owns the job can finish it, and only while waiting
   assign w_sel_done  = (r_snap_unit == UnitFpm) ? fpm_done : fact_done;
   assign w_complete  = (r_state == StWait) && w_sel_done;
   // Done on the final watchdog cycle takes priority over the timeout
   assign w_timeout   = (r_state == StWait) && !w_sel_done && w_expired;

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
   assign w_wd_clr = (r_state == StLaunch);
   assign w_wd_en  = (r_state == StWait);

   accel_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_wd_clr),
      .i_en      (w_wd_en),
      .o_expired (w_expired)
   );

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_start_acc) begin
               w_state_next = StLaunch;
            end
         end
         StLaunch: begin
            w_state_next = StWait;
         end
         StWait: begin
            if (w_complete || w_timeout) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // FSM: outputs
   always_comb begin
      w_busy  = (r_state != StIdle);
      fact_go = (r_state == StLaunch) && (r_snap_unit == UnitFact);
      fpm_go  = (r_state == StLaunch) && (r_snap_unit == UnitFpm);
   end

   // ------------------------------------------------------------------------
   // Sticky status next-state: job events first, then a CPU clear, then a
   // dropped start flags overrun (so clear+start while busy leaves overrun set)
   // ------------------------------------------------------------------------
   always_comb begin
      w_done_d    = r_done | w_complete | w_timeout;
      w_err_d     = w_complete ? ((r_snap_unit == UnitFact) && fact_err) : r_err;
      w_timeout_d = r_timeout | w_timeout;
      w_overrun_d = r_overrun;
      if (w_clear_req) begin
         w_done_d    = 1'b0;
         w_err_d     = 1'b0;
         w_timeout_d = 1'b0;
         w_overrun_d = 1'b0;
      end
      if (w_start_req && w_busy) begin
         w_overrun_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_opa       <= '0;
         r_opb       <= '0;
         r_result    <= '0;
         r_snap_a    <= '0;
         r_snap_b    <= '0;
         r_snap_unit <= UnitFact;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_timeout   <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (we && (addr == AddrOpa)) begin
            r_opa <= wdata;
         end
         if (we && (addr == AddrOpb)) begin
            r_opb <= wdata;
         end
         // Operands are frozen for the job so later OPA/OPB writes cannot disturb it
         if (w_start_acc) begin
            r_snap_a    <= r_opa;
            r_snap_b    <= r_opb;
            r_snap_unit <= wdata[CtrlUnit];
         end
         if (w_complete) begin
            r_result <= (r_snap_unit == UnitFpm) ? fpm_p : fact_result;
         end else if (w_timeout) begin
            r_result <= '0;
         end
         r_done    <= w_done_d;
         r_err     <= w_err_d;
         r_timeout <= w_timeout_d;
         r_overrun <= w_overrun_d;
      end
   end

   // ------------------------------------------------------------------------
   // Read mux and unit-facing outputs
   // ------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      unique case (addr)
         AddrCtrl:   rdata = pack_status(w_busy, r_done, r_err, r_timeout, r_overrun,
                                         r_snap_unit);
         AddrOpa:    rdata = r_opa;
         AddrOpb:    rdata = r_opb;
         AddrResult: rdata = r_result;
         default:    rdata = '0;
      endcase
   end

   assign fact_n     = r_snap_a[3:0];
   assign fpm_a      = r_snap_a;
   assign fpm_b      = r_snap_b;
   assign accel_done = r_done;

endmodule

// File: tb/tb_accel_sched.sv
// ---------------------------------------------------------------------------
// tb_accel_sched
// Two schedulers (TIMEOUT=256 and TIMEOUT=8) share one CPU bus and one set of
// unit responses. A job-level model tracks each instance by job age
// (1 = launch cycle, 2.. = waiting) and is compared every cycle; directed
// scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_accel_sched;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic        fact_done;
   logic        fact_err;
   logic [31:0] fact_result;
   logic        fpm_done;
   logic [31:0] fpm_p;

   logic [31:0] rdata      [2];
   logic        fact_go    [2];
   logic [3:0]  fact_n     [2];
   logic        fpm_go     [2];
   logic [31:0] fpm_a      [2];
   logic [31:0] fpm_b      [2];
   logic        accel_done [2];

   accel_sched #(.TIMEOUT(256)) u_dut0 (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata[0]),
      .fact_go(fact_go[0]), .fact_n(fact_n[0]), .fact_done(fact_done), .fact_err(fact_err),
      .fact_result(fact_result), .fpm_go(fpm_go[0]), .fpm_a(fpm_a[0]), .fpm_b(fpm_b[0]),
      .fpm_done(fpm_done), .fpm_p(fpm_p), .accel_done(accel_done[0])
   );

   accel_sched #(.TIMEOUT(8)) u_dut1 (
      .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata[1]),
      .fact_go(fact_go[1]), .fact_n(fact_n[1]), .fact_done(fact_done), .fact_err(fact_err),
      .fact_result(fact_result), .fpm_go(fpm_go[1]), .fpm_a(fpm_a[1]), .fpm_b(fpm_b[1]),
      .fpm_done(fpm_done), .fpm_p(fpm_p), .accel_done(accel_done[1])
   );

   // ------------------------------------------------------------------------
   // Job-level model
   // ------------------------------------------------------------------------
   typedef struct packed {
      logic        busy;
      logic [31:0] age;
      logic        done;
      logic        err;
      logic        to;
      logic        ov;
      logic        unit;
      logic [31:0] res;
      logic [31:0] opa;
      logic [31:0] opb;
      logic [31:0] sa;
      logic [31:0] sb;
   } mdl_t;

   mdl_t m [2];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         mdl_t        nx;
         logic        sd;
         logic [31:0] tmo;
         tmo = (k == 0) ? 32'd256 : 32'd8;
         nx  = m[k];
         if (reset) begin
            nx = '0;
         end else begin
            if (m[k].busy) begin
               sd = m[k].unit ? fpm_done : fact_done;
               if (m[k].age >= 2 && sd) begin
                  nx.busy = 1'b0;
                  nx.done = 1'b1;
                  nx.res  = m[k].unit ? fpm_p : fact_result;
                  nx.err  = m[k].unit ? 1'b0 : fact_err;
               end else if (m[k].age == tmo + 1) begin
                  nx.busy = 1'b0;
                  nx.done = 1'b1;
                  nx.to   = 1'b1;
                  nx.res  = '0;
               end else begin
                  nx.age = m[k].age + 1;
               end
            end
            if (we && addr == 2'd1) nx.opa = wdata;
            if (we && addr == 2'd2) nx.opb = wdata;
            if (we && addr == 2'd0) begin
               if (wdata[2]) begin
                  nx.done = 1'b0;
                  nx.err  = 1'b0;
                  nx.to   = 1'b0;
                  nx.ov   = 1'b0;
               end
               if (wdata[0]) begin
                  if (m[k].busy) begin
                     nx.ov = 1'b1;
                  end else begin
                     nx.busy = 1'b1;
                     nx.age  = 32'd1;
                     nx.unit = wdata[1];
                     nx.sa   = m[k].opa;
                     nx.sb   = m[k].opb;
                  end
               end
            end
         end
         m[k] <= nx;
      end
   end

   function automatic logic [31:0] exp_rdata(input mdl_t s, input logic [1:0] a);
      case (a)
         2'd0:    return {26'd0, s.unit, s.ov, s.to, s.err, s.done, s.busy};
         2'd1:    return s.opa;
         2'd2:    return s.opb;
         default: return s.res;
      endcase
   endfunction

   // ------------------------------------------------------------------------
   // Compare process (model checks every cycle, literal checks on request)
   // ------------------------------------------------------------------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic        chk_en;
   logic        lit_valid;
   string       lit_name;
   logic [31:0] lit_act;
   logic [31:0] lit_exp;
   int          fgo_cnt  [2] = '{0, 0};
   int          pgo_cnt  [2] = '{0, 0};
   int          busy_cnt [2] = '{0, 0};

   task automatic cmp(input string nm, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s inst%0d @%0t: got 0x%08h, expected 0x%08h", nm, k, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (lit_valid) cmp(lit_name, 9, lit_act, lit_exp);
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            cmp("rdata", k, rdata[k], exp_rdata(m[k], addr));
            cmp("fact_go", k, {31'd0, fact_go[k]},
                {31'd0, m[k].busy && m[k].age == 1 && !m[k].unit});
            cmp("fpm_go", k, {31'd0, fpm_go[k]},
                {31'd0, m[k].busy && m[k].age == 1 && m[k].unit});
            cmp("fact_n", k, {28'd0, fact_n[k]}, {28'd0, m[k].sa[3:0]});
            cmp("fpm_a", k, fpm_a[k], m[k].sa);
            cmp("fpm_b", k, fpm_b[k], m[k].sb);
            cmp("accel_done", k, {31'd0, accel_done[k]}, {31'd0, m[k].done});
            if (fact_go[k]) fgo_cnt[k]++;
            if (fpm_go[k]) pgo_cnt[k]++;
            if (addr == 2'd0 && rdata[k][0]) busy_cnt[k]++;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the rising edge)
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      tick(1);
      we = 1'b0; addr = 2'd0; wdata = '0;
   endtask

   task automatic pulse_fact(input logic [31:0] r, input logic e);
      fact_done = 1'b1; fact_result = r; fact_err = e;
      tick(1);
      fact_done = 1'b0; fact_result = '0; fact_err = 1'b0;
   endtask

   task automatic pulse_fpm(input logic [31:0] p);
      fpm_done = 1'b1; fpm_p = p;
      tick(1);
      fpm_done = 1'b0; fpm_p = '0;
   endtask

   task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
      lit_name = nm; lit_act = act; lit_exp = exp; lit_valid = 1'b1;
      @(negedge clk);
      #1;
      lit_valid = 1'b0;
      tick(1);
   endtask

   task automatic chk_reg(input string nm, input int k, input logic [1:0] a,
                          input logic [31:0] exp);
      logic [31:0] v;
      addr = a;
      @(negedge clk);
      v = rdata[k];
      tick(1);
      addr = 2'd0;
      lit(nm, v, exp);
   endtask

   int fb [2];
   int pb [2];
   int bb [2];

   task automatic mark();
      for (int k = 0; k < 2; k++) begin
         fb[k] = fgo_cnt[k];
         pb[k] = pgo_cnt[k];
         bb[k] = busy_cnt[k];
      end
   endtask

   // ------------------------------------------------------------------------
   // Directed scenarios
   // ------------------------------------------------------------------------
   initial begin
      reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = '0;
      fact_done = 1'b0; fact_err = 1'b0; fact_result = '0;
      fpm_done = 1'b0; fpm_p = '0;
      chk_en = 1'b0; lit_valid = 1'b0;
      tick(2);
      chk_en = 1'b1;
      lit("reset_status0", rdata[0], 32'h0);
      reset = 1'b0;
      tick(1);

      // FPM job; a stray factorial done during the job must be ignored
      wr(2'd1, 32'h4000_0000);
      wr(2'd2, 32'h4040_0000);
      mark();
      wr(2'd0, 32'h3);
      tick(1);
      pulse_fact(32'h999, 1'b0);
      pulse_fpm(32'h40C0_0000);
      lit("fpm_no_fact_go", fgo_cnt[0] - fb[0], 0);
      lit("fpm_one_go", pgo_cnt[0] - pb[0], 1);
      chk_reg("fpm_result0", 0, 2'd3, 32'h40C0_0000);
      chk_reg("fpm_status0", 0, 2'd0, 32'h22);
      chk_reg("fpm_status1", 1, 2'd0, 32'h22);

      // Factorial 5!: done 11 cycles after launch; the TIMEOUT=8 copy expires
      wr(2'd1, 32'd5);
      mark();
      wr(2'd0, 32'h1);
      tick(11);
      pulse_fact(32'd120, 1'b0);
      lit("fact_busy_cycles0", busy_cnt[0] - bb[0], 12);
      lit("fact_go_pulses0", fgo_cnt[0] - fb[0], 1);
      lit("timeout_busy_cycles1", busy_cnt[1] - bb[1], 9);
      chk_reg("fact_result0", 0, 2'd3, 32'd120);
      chk_reg("fact_status0", 0, 2'd0, 32'h02);
      chk_reg("timeout_result1", 1, 2'd3, 32'h0);
      chk_reg("timeout_status1", 1, 2'd0, 32'h0A);

      // Clear+start; done on the 8th wait cycle wins over the timeout
      wr(2'd0, 32'h5);
      tick(8);
      pulse_fact(32'd24, 1'b0);
      chk_reg("lastcycle_result1", 1, 2'd3, 32'd24);
      chk_reg("lastcycle_status1", 1, 2'd0, 32'h02);

      // Overrun and operand snapshot
      mark();
      wr(2'd0, 32'h1);
      wr(2'd1, 32'd7);
      wr(2'd0, 32'h1);
      lit("snapshot_fact_n", {28'd0, fact_n[0]}, 32'd5);
      pulse_fact(32'd120, 1'b0);
      lit("overrun_one_go", fgo_cnt[0] - fb[0], 1);
      chk_reg("overrun_status0", 0, 2'd0, 32'h12);
      wr(2'd0, 32'h5);
      lit("new_job_fact_n", {28'd0, fact_n[1]}, 32'd7);
      pulse_fact(32'd5040, 1'b0);
      chk_reg("after_clear_status0", 0, 2'd0, 32'h02);
      chk_reg("after_clear_result1", 1, 2'd3, 32'd5040);

      // Factorial overflow, then clear
      wr(2'd0, 32'h1);
      tick(2);
      pulse_fact(32'hDEAD_BEEF, 1'b1);
      chk_reg("overflow_status0", 0, 2'd0, 32'h06);
      wr(2'd0, 32'h4);
      chk_reg("cleared_status0", 0, 2'd0, 32'h00);
      chk_reg("cleared_status1", 1, 2'd0, 32'h00);

      // Reset in WAIT, late done afterwards
      mark();
      wr(2'd0, 32'h1);
      tick(2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      pulse_fact(32'd77, 1'b0);
      tick(2);
      lit("reset_go_pulses0", fgo_cnt[0] - fb[0], 1);
      lit("reset_accel_done0", {31'd0, accel_done[0]}, 32'd0);
      chk_reg("reset_status0", 0, 2'd0, 32'h0);
      chk_reg("reset_result0", 0, 2'd3, 32'h0);
      chk_reg("reset_result1", 1, 2'd3, 32'h0);

      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
